// File: rtl/cdb_broadcast_queue_if.sv
// Signal bundle between the FU completion side and the CDB broadcast side of
// cdb_broadcast_queue. The queue itself connects through the slave modport.
interface cdb_broadcast_queue_if #(
  parameter int NUM_FU     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 7,
  parameter int DEPTH      = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [NUM_FU-1:0]            fu_done;
  logic [NUM_FU-1:0]            fu_issue;
  logic [NUM_FU*DATA_WIDTH-1:0] fu_result;
  logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag;
  logic [NUM_FU-1:0]            fu_queued;
  logic                         cdb_valid;
  logic [DATA_WIDTH-1:0]        cdb_data;
  logic [TAG_WIDTH-1:0]         cdb_tag;
  logic                         cdb_ready;
  logic                         full;
  logic                         empty;
  logic [CNT_W-1:0]             count;

  modport slave (
    input  fu_done, fu_issue, fu_result, fu_tag, cdb_ready,
    output fu_queued, cdb_valid, cdb_data, cdb_tag, full, empty, count
  );

  modport master (
    output fu_done, fu_issue, fu_result, fu_tag, cdb_ready,
    input  fu_queued, cdb_valid, cdb_data, cdb_tag, full, empty, count
  );
endinterface

// File: rtl/cdb_broadcast_queue.sv
// Round-robin collector of FU results into a circular FIFO whose head is
// broadcast on the CDB. All outputs come straight from registers.
module cdb_broadcast_queue #(
  parameter int NUM_FU     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 7,
  parameter int DEPTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  cdb_broadcast_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int ENT_W = TAG_WIDTH + DATA_WIDTH;

  // Index base+k wrapped into 0..NUM_FU-1 (NUM_FU need not be a power of two).
  function automatic logic [FU_W-1:0] rr_index(input logic [FU_W-1:0] base, input int k);
    return FU_W'((int'(base) + k) % NUM_FU);
  endfunction

  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              valid_q, valid_d;
  logic [ENT_W-1:0]  head_q, head_d;
  logic [FU_W-1:0]   rr_q, rr_d;
  logic [NUM_FU-1:0] taken_q, taken_d;
  logic [NUM_FU-1:0] queued_q, queued_d;

  logic [NUM_FU-1:0] cand_s;
  logic              found_s;
  logic [FU_W-1:0]   win_s;
  logic              push_s;
  logic              pop_s;
  logic [ENT_W-1:0]  win_entry_s;

  assign cand_s = bus.fu_done & ~taken_q & ~bus.fu_issue;

  // Round-robin search: walking from the far end means the last hit is the
  // candidate closest to rr_q.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      win_s   = cand_s[rr_index(rr_q, k)] ? rr_index(rr_q, k) : win_s;
      found_s = found_s | cand_s[rr_index(rr_q, k)];
    end
  end

  // Next-state logic for pointers, count, flags and the registered head.
  always_comb begin
    push_s      = found_s & ~full_q;
    pop_s       = valid_q & bus.cdb_ready;
    win_entry_s = {bus.fu_tag[win_s*TAG_WIDTH +: TAG_WIDTH],
                   bus.fu_result[win_s*DATA_WIDTH +: DATA_WIDTH]};

    wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    rr_d     = push_s ? rr_index(win_s, 1) : rr_q;

    for (int i = 0; i < NUM_FU; i++) begin
      queued_d[i] = push_s && (win_s == FU_W'(i));
      taken_d[i]  = queued_d[i] | (taken_q[i] & ~bus.fu_issue[i]);
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
    valid_d = ~empty_d;

    // The new head can be the entry written this very cycle.
    if (empty_d) begin
      head_d = '0;
    end else if (push_s && (rd_ptr_d == wr_ptr_q)) begin
      head_d = win_entry_s;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // State registers and storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      valid_q  <= 1'b0;
      head_q   <= '0;
      rr_q     <= '0;
      taken_q  <= '0;
      queued_q <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= win_entry_s;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
      rr_q     <= rr_d;
      taken_q  <= taken_d;
      queued_q <= queued_d;
    end
  end

  assign bus.fu_queued = queued_q;
  assign bus.cdb_valid = valid_q;
  assign bus.cdb_data  = head_q[DATA_WIDTH-1:0];
  assign bus.cdb_tag   = head_q[ENT_W-1 -: TAG_WIDTH];
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_cdb_broadcast_queue.sv
// Directed bench for cdb_broadcast_queue: a queue-based reference model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_cdb_broadcast_queue;
  localparam int NUM_FU = 4;
  localparam int DW     = 32;
  localparam int TW     = 7;
  localparam int DEPTH  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cdb_broadcast_queue_if #(.NUM_FU(NUM_FU), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) bus ();

  cdb_broadcast_queue #(.NUM_FU(NUM_FU), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a queue of {tag,data}, per-FU taken flags, rr pointer.
  logic [TW+DW-1:0] mq[$];
  logic [NUM_FU-1:0] m_taken;
  logic [NUM_FU-1:0] m_queued;
  int                m_rr;
  logic [NUM_FU-1:0] m_cand;
  int                m_w;
  bit                m_push;
  bit                m_pop;
  logic [TW+DW-1:0]  m_ent;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_taken  = '0;
      m_queued = '0;
      m_rr     = 0;
    end else begin
      m_cand = bus.fu_done & ~m_taken & ~bus.fu_issue;
      m_w = -1;
      for (int k = 0; k < NUM_FU; k++)
        if (m_w < 0 && m_cand[(m_rr + k) % NUM_FU]) m_w = (m_rr + k) % NUM_FU;
      m_push   = (m_w >= 0) && (mq.size() < DEPTH);
      m_pop    = (mq.size() > 0) && bus.cdb_ready;
      m_taken  = m_taken & ~bus.fu_issue;
      m_queued = '0;
      if (m_push) begin
        m_ent = {bus.fu_tag[m_w*TW +: TW], bus.fu_result[m_w*DW +: DW]};
        m_taken[m_w]  = 1'b1;
        m_queued[m_w] = 1'b1;
        m_rr = (m_w + 1) % NUM_FU;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(m_ent);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("fu_queued", 64'(bus.fu_queued), 64'(m_queued));
      check("cdb_valid", 64'(bus.cdb_valid), 64'(mq.size() > 0));
      check("cdb_data",  64'(bus.cdb_data),  (mq.size() > 0) ? 64'(mq[0][DW-1:0]) : 64'd0);
      check("cdb_tag",   64'(bus.cdb_tag),   (mq.size() > 0) ? 64'(mq[0][TW+DW-1:DW]) : 64'd0);
      check("count",     64'(bus.count),     64'(mq.size()));
      check("full",      64'(bus.full),      64'(mq.size() == DEPTH));
      check("empty",     64'(bus.empty),     64'(mq.size() == 0));
    end
  end

  logic [TW-1:0] pop_log[$];
  always @(posedge clk) begin
    if (!rst && bus.cdb_valid && bus.cdb_ready) pop_log.push_back(bus.cdb_tag);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_fu(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
    bus.fu_tag[i*TW +: TW]    = t;
    bus.fu_result[i*DW +: DW] = d;
    bus.fu_done[i]            = 1'b1;
  endtask

  task automatic issue(input logic [NUM_FU-1:0] m);
    bus.fu_issue = m;
    bus.fu_done  = bus.fu_done & ~m;
    tick(1);
    bus.fu_issue = '0;
  endtask

  logic [TW-1:0] exp_order [10];
  logic [NUM_FU-1:0] one_hot;

  initial begin
    exp_order = '{7'h31, 7'h32, 7'h33, 7'h30, 7'h35, 7'h36, 7'h37, 7'h34, 7'h39, 7'h38};
    bus.fu_done   = '0;
    bus.fu_issue  = '0;
    bus.fu_result = '0;
    bus.fu_tag    = '0;
    bus.cdb_ready = 1'b0;
    tick(2);
    cmp_en = 1'b1;
    rst    = 1'b0;
    check("rst_empty", 64'(bus.empty), 64'd1);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_valid", 64'(bus.cdb_valid), 64'd0);
    check("rst_queued", 64'(bus.fu_queued), 64'd0);
    check("rst_data", 64'(bus.cdb_data), 64'd0);

    // Simultaneous completion with rr at 0 and no consumer.
    for (int i = 0; i < NUM_FU; i++) set_fu(i, 7'(8'h10 + i), 32'(32'hA0 + i));
    one_hot = 4'b0001;
    for (int k = 0; k < NUM_FU; k++) begin
      tick(1);
      check("sim_queued", 64'(bus.fu_queued), 64'(one_hot << k));
      check("sim_count", 64'(bus.count), 64'(k + 1));
      check("sim_head", 64'(bus.cdb_tag), 64'h10);
    end
    tick(1);
    check("sim_peak", 64'(bus.count), 64'd4);
    check("sim_noack", 64'(bus.fu_queued), 64'd0);
    bus.cdb_ready = 1'b1;
    for (int k = 1; k <= NUM_FU; k++) begin
      tick(1);
      check("sim_drain_cnt", 64'(bus.count), 64'(NUM_FU - k));
      if (k < NUM_FU) check("sim_drain_tag", 64'(bus.cdb_tag), 64'(8'h10 + k));
    end

    // Single FU: one acknowledge, no duplicate while fu_done stays high.
    issue(4'b0001);
    set_fu(0, 7'h05, 32'hDEADBEEF);
    tick(1);
    check("one_queued", 64'(bus.fu_queued), 64'd1);
    check("one_valid", 64'(bus.cdb_valid), 64'd1);
    check("one_tag", 64'(bus.cdb_tag), 64'h05);
    check("one_data", 64'(bus.cdb_data), 64'hDEADBEEF);
    tick(10);
    check("one_nodup", 64'(bus.count), 64'd0);

    // Fill and backpressure: 10 results, 8 slots, then drain in order.
    bus.cdb_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      issue(4'b1111);
      for (int i = 0; i < NUM_FU; i++) set_fu(i, 7'(8'h30 + r*4 + i), 32'(32'hC000_0030 + r*4 + i));
      tick(4);
    end
    check("fill_full", 64'(bus.full), 64'd1);
    check("fill_count", 64'(bus.count), 64'd8);
    issue(4'b0011);
    set_fu(0, 7'h38, 32'hC000_0038);
    set_fu(1, 7'h39, 32'hC000_0039);
    tick(3);
    check("fill_pending", 64'(bus.fu_queued), 64'd0);
    check("fill_still", 64'(bus.count), 64'd8);
    pop_log.delete();
    bus.cdb_ready = 1'b1;
    tick(1);
    check("fullpop_count", 64'(bus.count), 64'd7);
    check("fullpop_noack", 64'(bus.fu_queued), 64'd0);
    tick(1);
    check("late_push_ack", 64'(bus.fu_queued), 64'b0010);
    check("late_push_cnt", 64'(bus.count), 64'd7);
    tick(1);
    check("late_push_ack2", 64'(bus.fu_queued), 64'b0001);
    tick(8);
    check("drain_empty", 64'(bus.empty), 64'd1);
    check("drain_n", 64'(pop_log.size()), 64'd10);
    for (int i = 0; i < 10; i++)
      check("drain_order", (i < pop_log.size()) ? 64'(pop_log[i]) : 64'h7f, 64'(exp_order[i]));

    // Re-dispatch of FU1 while its fu_done stays high with a new result.
    bus.fu_issue = 4'b0010;
    set_fu(1, 7'h22, 32'h0000_1234);
    tick(1);
    bus.fu_issue = '0;
    check("redisp_block", 64'(bus.fu_queued), 64'd0);
    tick(1);
    check("redisp_ack", 64'(bus.fu_queued), 64'b0010);
    check("redisp_tag", 64'(bus.cdb_tag), 64'h22);
    check("redisp_data", 64'(bus.cdb_data), 64'h1234);
    tick(5);
    check("redisp_once", 64'(bus.count), 64'd0);

    // Reset with 5 stored entries and 2 pending FUs.
    bus.cdb_ready = 1'b0;
    issue(4'b1111);
    for (int i = 0; i < NUM_FU; i++) set_fu(i, 7'(8'h40 + i), 32'(32'hB000_0040 + i));
    tick(4);
    issue(4'b0111);
    for (int i = 0; i < 3; i++) set_fu(i, 7'(8'h48 + i), 32'(32'hB000_0048 + i));
    tick(1);
    check("pre_rst_count", 64'(bus.count), 64'd5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_empty", 64'(bus.empty), 64'd1);
    check("mid_rst_count", 64'(bus.count), 64'd0);
    check("mid_rst_valid", 64'(bus.cdb_valid), 64'd0);
    check("mid_rst_queued", 64'(bus.fu_queued), 64'd0);
    tick(5);
    check("post_rst_reaccept", 64'(bus.count), 64'd4);
    bus.cdb_ready = 1'b1;
    tick(6);
    check("final_empty", 64'(bus.empty), 64'd1);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cdb_broadcast_queue.md
# cdb_broadcast_queue

Result collection queue between the functional units and the common data bus (CDB). It accepts at most one completed result per cycle from NUM_FU functional units using round-robin arbitration. Each accepted result is stored in a circular FIFO, and the FU receives the `queued` acknowledge that lets it return to idle. The FIFO head is broadcast on the CDB under a valid/ready handshake.

## Interface
Parameters:
- NUM_FU, 4, number of functional units attached
- DATA_WIDTH, 32, result width
- TAG_WIDTH, 7, execution tag width
- DEPTH, 8, FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- fu_done  in  NUM_FU  per-FU done level; held high until the FU is re-dispatched
- fu_issue  in  NUM_FU  per-FU dispatch strobe (the FU's ce)
- fu_result  in  NUM_FU*DATA_WIDTH  packed results; FU i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- fu_tag  in  NUM_FU*TAG_WIDTH  packed execution tags, same packing
- fu_queued  out  NUM_FU  one-cycle acknowledge per FU
- cdb_valid  out  1  head entry valid
- cdb_data  out  DATA_WIDTH  head result
- cdb_tag  out  TAG_WIDTH  head tag
- cdb_ready  in  1  CDB consumer accepts the head this cycle
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  clog2(DEPTH)+1  occupied entries

## Operation
- Per-FU `taken[i]` flag:
  - Set when FU i's result is accepted.
  - Cleared by `fu_issue[i]`.
  - Prevents re-enqueueing a `fu_done` that is still held high after acceptance.
- Candidate: `cand[i] = fu_done[i] & ~taken[i] & ~fu_issue[i]`.
- Arbitration: round-robin pointer `rr` (0..NUM_FU-1).
  - Search `rr, rr+1, …` modulo NUM_FU; the first candidate wins.
  - On grant to FU i, `rr <= (i+1) mod NUM_FU`.
  - With no grant, `rr` holds.
- Push when any candidate exists and `full==0`. `full` is the registered value from the start of the cycle; a same-cycle pop does not free the slot for a push.
  - On push, the winner's `{tag, result}` is written at `wr_ptr`.
  - `wr_ptr` increments modulo DEPTH.
  - `taken[winner]` is set.
  - `fu_queued[winner]` is 1 for the following cycle only.
- Pop when `cdb_valid & cdb_ready`: `rd_ptr` increments modulo DEPTH.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- CDB outputs:
  - `cdb_valid = ~empty`.
  - `cdb_data` and `cdb_tag` come from the entry at `rd_ptr`.
  - When empty, `cdb_data` and `cdb_tag` are 0.
- Losing candidates stay pending. No result is dropped or duplicated.

## Timing
- Reset values:
  - `fu_queued=0`, `cdb_valid=0`, `cdb_data=0`, `cdb_tag=0`.
  - `full=0`, `empty=1`, `count=0`.
  - Pointers, `rr` and all `taken` flags are 0.
- Reset mid-operation discards all stored entries and pending acknowledges.
- Latency with the queue empty, for a candidate at cycle t:
  - Pushed at edge t.
  - `cdb_valid` and `fu_queued[i]` are high in cycle t+1.
  - There is no combinational bypass from `fu_*` to `cdb_*`.
- Throughput: one push and one pop per cycle sustained.
- Head stability: `cdb_data` and `cdb_tag` stay stable while `cdb_valid & ~cdb_ready`.
- `fu_issue[i]` in the same cycle as `cand[i]`: FU i is not a candidate, and its `taken` flag clears.
- Pointer wrap: both pointers wrap DEPTH-1 → 0. `full` and `empty` are derived from `count`, not from pointer equality.

## Test plan
- Single FU:
  - Stimulus: FU0 raises `fu_done` with tag 0x05 and data 0xDEADBEEF; `cdb_ready=1`.
  - Response: `fu_queued[0]` pulses once; `cdb_valid` is high one cycle later with 0x05 / 0xDEADBEEF.
  - Then: `fu_done[0]` held high for 10 more cycles produces no second entry.
- Simultaneous completion:
  - Stimulus: all 4 FUs raise `fu_done` in the same cycle with `rr=0`.
  - Response: pushed in order FU0, FU1, FU2, FU3 over 4 cycles; each `fu_queued` pulses exactly once; `count` peaks correctly with `cdb_ready=0`.
- Fill and backpressure:
  - Stimulus: `cdb_ready=0`; feed 10 distinct results.
  - Response: `full=1` after 8 pushes; the remaining 2 FUs get no acknowledge and stay pending.
  - Then: raise `cdb_ready`; all 10 emerge in acceptance order.
- Full with simultaneous pop:
  - Stimulus: `count=8`, `cdb_ready=1`, 1 candidate.
  - Response: that cycle pop only, `count` goes to 7; the push lands the next cycle.
  - Also verify `wr_ptr` and `rd_ptr` wrap past entry 7 with intact data.
- Re-dispatch:
  - Stimulus: FU1 is acknowledged, then `fu_issue[1]` pulses; `fu_done[1]` stays high with new tag 0x22 and data 0x1234.
  - Response: the new result is enqueued once after the issue cycle.
- Reset mid-operation:
  - Stimulus: 5 entries queued and 2 pending FUs; assert `rst` for 1 cycle.
  - Response: `empty=1`, `count=0`, `cdb_valid=0`, no `fu_queued` pulse; FUs with `fu_done` still high are re-accepted afterward.
